tow_match_ctrl: RTL and testbench

Match controller for the tug-of-war playfield. Converts the two players' held buttons into single-cycle move strobes for the playfield and arbitrates presses that arrive in the same cycle. It detects when a point is won, keeps per-player scores, holds the field during the point display, re-centres the field, and declares the match winner at a parameterised score.

---
 rtl/tow_match_ctrl.sv | 111 +++++++++++
 tb/tb_tow_match_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/tow_match_ctrl.sv
// tow_match_ctrl: tug-of-war match FSM; turns button edges into playfield strobes and keeps score.
module tow_match_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       key_l,
  input  logic       key_r,
  input  logic [9:0] field_led,
  output logic       pf_reset,
  output logic       pf_lin,
  output logic       pf_rin,
  output logic [2:0] score_l,
  output logic [2:0] score_r,
  output logic       point_l,
  output logic       point_r,
  output logic [1:0] winner,
  output logic       playing
);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [2:0] WIN = 3'(WIN_SCORE);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, CENTRE, PLAY, HOLD, MATCH_OVER} state_t;
  state_t state;
  logic key_l_d, key_r_d, press_l, press_r;
  logic [CW-1:0] cnt;
  assign press_l = key_l & ~key_l_d;
  assign press_r = key_r & ~key_r_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      key_l_d  <= 1'b0;
      key_r_d  <= 1'b0;
      cnt      <= '0;
      pf_reset <= 1'b0;
      pf_lin   <= 1'b0;
      pf_rin   <= 1'b0;
      point_l  <= 1'b0;
      point_r  <= 1'b0;
      score_l  <= 3'd0;
      score_r  <= 3'd0;
      winner   <= 2'b00;
      playing  <= 1'b0;
    end else begin
      key_l_d  <= key_l;
      key_r_d  <= key_r;
      pf_reset <= 1'b0;
      pf_lin   <= 1'b0;
      pf_rin   <= 1'b0;
      point_l  <= 1'b0;
      point_r  <= 1'b0;
      case (state)
        IDLE: begin
          score_l <= 3'd0;
          score_r <= 3'd0;
          if (start) begin
            state    <= CENTRE;
            pf_reset <= 1'b1;
          end
        end
        CENTRE: begin
          state   <= PLAY;
          playing <= 1'b1;
        end
        PLAY: begin
          // simultaneous presses cancel each other
          if (press_r && !press_l) begin
            if (field_led[1]) begin
              score_r <= score_r + {2'b00, score_r != 3'd7};
              point_r <= 1'b1;
              state   <= HOLD;
              cnt     <= HOLD_LOAD;
              playing <= 1'b0;
            end else pf_rin <= 1'b1;
          end else if (press_l && !press_r) begin
            if (field_led[8]) begin
              score_l <= score_l + {2'b00, score_l != 3'd7};
              point_l <= 1'b1;
              state   <= HOLD;
              cnt     <= HOLD_LOAD;
              playing <= 1'b0;
            end else pf_lin <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            if (score_l == WIN || score_r == WIN) begin
              state  <= MATCH_OVER;
              winner <= (score_l == WIN) ? 2'b10 : 2'b01;
            end else begin
              state    <= CENTRE;
              pf_reset <= 1'b1;
            end
          end else cnt <= cnt - 1'b1;
        end
        MATCH_OVER: begin
          if (start) begin
            score_l  <= 3'd0;
            score_r  <= 3'd0;
            winner   <= 2'b00;
            state    <= CENTRE;
            pf_reset <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tow_match_ctrl.sv
// tb_tow_match_ctrl: table-driven checks of the match controller with WIN_SCORE=2, HOLD_CYCLES=4.
module tb_tow_match_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, key_l = 1'b0, key_r = 1'b0;
  logic [9:0] field_led = 10'h020;
  logic pf_reset, pf_lin, pf_rin, point_l, point_r, playing;
  logic [2:0] score_l, score_r;
  logic [1:0] winner;
  logic [13:0] outs;
  int checks = 0, errors = 0;
  typedef struct {
    logic s, l, r;
    logic [9:0] led;
    logic [13:0] exp;
  } vec_t;
  vec_t v[$];

  tow_match_ctrl #(.WIN_SCORE(2), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .key_l(key_l), .key_r(key_r),
    .field_led(field_led), .pf_reset(pf_reset), .pf_lin(pf_lin), .pf_rin(pf_rin),
    .score_l(score_l), .score_r(score_r), .point_l(point_l), .point_r(point_r),
    .winner(winner), .playing(playing)
  );

  always #5 clk = ~clk;
  assign outs = {pf_reset, pf_lin, pf_rin, point_l, point_r, score_l, score_r, winner, playing};

  function automatic logic [13:0] e(input logic prst, lin, rin, pl, pr,
                                    input logic [2:0] sl, sr, input logic [1:0] w, input logic play);
    return {prst, lin, rin, pl, pr, sl, sr, w, play};
  endfunction

  task automatic add(input logic s, l, r, input logic [9:0] led, input logic [13:0] exp);
    v.push_back('{s: s, l: l, r: r, led: led, exp: exp});
  endtask

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (prst lin rin pl pr sl sr win play)", name, act, exp);
    end
  endtask

  initial begin
    add(1, 0, 0, 10'h020, e(1, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    add(0, 0, 0, 10'h020, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    add(0, 0, 1, 10'h020, e(0, 0, 1, 0, 0, 0, 0, 2'b00, 1));
    for (int i = 0; i < 4; i++) add(0, 0, 1, 10'h020, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    add(0, 0, 0, 10'h020, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    add(0, 0, 1, 10'h020, e(0, 0, 1, 0, 0, 0, 0, 2'b00, 1));
    add(0, 0, 0, 10'h020, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    add(0, 1, 1, 10'h020, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    add(0, 0, 0, 10'h020, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    add(0, 1, 0, 10'h020, e(0, 1, 0, 0, 0, 0, 0, 2'b00, 1));
    add(0, 0, 0, 10'h020, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    add(0, 0, 1, 10'h002, e(0, 0, 0, 0, 1, 0, 1, 2'b00, 0));
    add(0, 0, 0, 10'h002, e(0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    add(0, 0, 1, 10'h002, e(0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    add(0, 0, 0, 10'h002, e(0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    add(0, 0, 0, 10'h002, e(1, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    add(0, 0, 0, 10'h100, e(0, 0, 0, 0, 0, 0, 1, 2'b00, 1));
    add(0, 1, 0, 10'h100, e(0, 0, 0, 1, 0, 1, 1, 2'b00, 0));
    add(0, 0, 0, 10'h100, e(0, 0, 0, 0, 0, 1, 1, 2'b00, 0));
    add(0, 1, 0, 10'h100, e(0, 0, 0, 0, 0, 1, 1, 2'b00, 0));
    add(0, 0, 0, 10'h100, e(0, 0, 0, 0, 0, 1, 1, 2'b00, 0));
    add(0, 0, 0, 10'h100, e(1, 0, 0, 0, 0, 1, 1, 2'b00, 0));
    add(0, 0, 0, 10'h100, e(0, 0, 0, 0, 0, 1, 1, 2'b00, 1));
    add(0, 1, 0, 10'h100, e(0, 0, 0, 1, 0, 2, 1, 2'b00, 0));
    for (int i = 0; i < 3; i++) add(0, 0, 0, 10'h100, e(0, 0, 0, 0, 0, 2, 1, 2'b00, 0));
    add(0, 0, 0, 10'h100, e(0, 0, 0, 0, 0, 2, 1, 2'b10, 0));
    add(0, 0, 0, 10'h100, e(0, 0, 0, 0, 0, 2, 1, 2'b10, 0));
    add(1, 0, 0, 10'h100, e(1, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    add(1, 0, 0, 10'h100, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    add(1, 0, 0, 10'h100, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    add(0, 0, 1, 10'h020, e(0, 0, 1, 0, 0, 0, 0, 2'b00, 1));
    add(0, 0, 0, 10'h020, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 1));

    #12 chk("reset_state", outs, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    @(negedge clk) reset = 1'b0;
    foreach (v[i]) begin
      @(negedge clk);
      start = v[i].s; key_l = v[i].l; key_r = v[i].r; field_led = v[i].led;
      @(posedge clk) #1;
      chk($sformatf("vec%0d", i), outs, v[i].exp);
    end

    // right scores, then reset lands between edges in the first HOLD cycle
    @(negedge clk) field_led = 10'h002; key_r = 1'b1;
    @(posedge clk) #1 chk("point_before_rst", outs, e(0, 0, 0, 0, 1, 0, 1, 2'b00, 0));
    #2 reset = 1'b1;
    #1 chk("async_rst", outs, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    @(negedge clk) reset = 1'b0; key_r = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("idle_after_rst", outs, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 chk("restart_centre", outs, e(1, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    @(negedge clk) start = 1'b0;
    @(posedge clk) #1 chk("restart_play", outs, e(0, 0, 0, 0, 0, 0, 0, 2'b00, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
